// File: rtl/data_bus_bridge.sv
// data_bus_bridge: load/store unit between the RV32I datapath memory port and an
// APB-style data bus. Issues a SETUP/ACCESS handshake with a wait-state timeout,
// builds byte strobes and lane-aligned write data for stores, and extracts and
// sign/zero-extends load data for the register-file write mux.
//
// Ports:
//   iClk, iRst          clock, asynchronous active-high reset
//   iReq_Rd / iReq_Wr   load / store request (sampled in IDLE only)
//   iFunct3             access size and sign
//   iAddr, iWrData      byte address, store source data (rs2)
//   oRdData             extended load data, valid in DONE, held afterwards
//   oStall              hold PC / suppress register write until DONE
//   oErr                one-cycle fault pulse in DONE
//   oPSel, oPEnable, oPWrite, oPAddr, oPWData, oPStrb   bus master outputs
//   iPRData, iPReady, iPSlvErr                         bus slave response
module data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq_Rd,
    input  logic        iReq_Wr,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oStall,
    output logic        oErr,
    output logic        oPSel,
    output logic        oPEnable,
    output logic        oPWrite,
    output logic [31:0] oPAddr,
    output logic [31:0] oPWData,
    output logic [3:0]  oPStrb,
    input  logic [31:0] iPRData,
    input  logic        iPReady,
    input  logic        iPSlvErr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state;
    logic [1:0]         off_q;
    logic [2:0]         f3_q;
    logic               wr_q;
    logic [CNT_W-1:0]   cnt;

    logic               req;
    logic               illegal;
    logic [3:0]         strb_c;
    logic [31:0]        wdata_c;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_ext;

    assign req = iReq_Rd | iReq_Wr;

    // Request legality: conflicting request, unsupported funct3, misalignment
    always_comb begin
        illegal = 1'b0;
        if (iReq_Rd && iReq_Wr) begin
            illegal = 1'b1;
        end else if (iReq_Rd) begin
            if (iFunct3 == 3'b011 || iFunct3 == 3'b110 || iFunct3 == 3'b111)
                illegal = 1'b1;
        end else if (iFunct3 > 3'b010) begin
            illegal = 1'b1;
        end
        if (iFunct3[1:0] == 2'b01 && iAddr[0])
            illegal = 1'b1;
        if (iFunct3[1:0] == 2'b10 && iAddr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    // Store lane placement from the live request (captured on the IDLE->SETUP edge)
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = 32'h0;
        if (iReq_Wr) begin
            case (iFunct3[1:0])
                2'b00: begin
                    strb_c  = 4'b0001 << iAddr[1:0];
                    wdata_c = {4{iWrData[7:0]}};
                end
                2'b01: begin
                    strb_c  = 4'b0011 << iAddr[1:0];
                    wdata_c = {2{iWrData[15:0]}};
                end
                2'b10: begin
                    strb_c  = 4'b1111;
                    wdata_c = iWrData;
                end
                default: begin
                    strb_c  = 4'b0000;
                    wdata_c = 32'h0;
                end
            endcase
        end
    end

    // Load extraction from the bus word using the latched offset and funct3
    always_comb begin
        rd_byte = iPRData[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? iPRData[31:16] : iPRData[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'h0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'h0, rd_half};
            3'b010:  rd_ext = iPRData;
            default: rd_ext = 32'h0;
        endcase
    end

    // Stall is combinational in IDLE so the requesting instruction is held at once
    always_comb begin
        if (iRst)
            oStall = 1'b0;
        else if (state == IDLE)
            oStall = req;
        else
            oStall = (state != DONE);
    end

    // Access sequencer with registered bus and result outputs
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
            wr_q     <= 1'b0;
            cnt      <= '0;
            oRdData  <= 32'h0;
            oErr     <= 1'b0;
            oPSel    <= 1'b0;
            oPEnable <= 1'b0;
            oPWrite  <= 1'b0;
            oPAddr   <= 32'h0;
            oPWData  <= 32'h0;
            oPStrb   <= 4'b0000;
        end else begin
            oErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        off_q <= iAddr[1:0];
                        f3_q  <= iFunct3;
                        wr_q  <= iReq_Wr;
                        if (illegal) begin
                            oErr    <= 1'b1;
                            oRdData <= 32'h0;
                            state   <= DONE;
                        end else begin
                            oPSel   <= 1'b1;
                            oPWrite <= iReq_Wr;
                            oPAddr  <= {iAddr[31:2], 2'b00};
                            oPStrb  <= strb_c;
                            oPWData <= wdata_c;
                            state   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    oPEnable <= 1'b1;
                    cnt      <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (iPReady) begin
                        oPSel    <= 1'b0;
                        oPEnable <= 1'b0;
                        oErr     <= iPSlvErr;
                        oRdData  <= (wr_q || iPSlvErr) ? 32'h0 : rd_ext;
                        state    <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        oPSel    <= 1'b0;
                        oPEnable <= 1'b0;
                        oErr     <= 1'b1;
                        oRdData  <= 32'h0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
